// File: rtl/axicb_rr_arbiter_lock.sv
// Round-robin arbiter with multi-level priority and a locked (registered) grant.
//
// A grant is chosen among the requesters at the highest asserted priority
// level. Each priority level keeps its own round-robin mask so that
// requesters at that level take turns. Once issued, the grant is held until
// the owner pulses done. If another request is pending in that same cycle,
// a new grant is issued on the same edge, so there is no idle bubble.
//
// Ports:
//   aclk        clock, rising edge
//   areset      asynchronous reset, active-high
//   srst        synchronous reset, active-high
//   en          arbitration enable (no new grant while low)
//   req         request vector, one bit per requester
//   prio        per-requester priority, requester i in [i*PRIO_W +: PRIO_W]
//   done        owner releases its grant (single-cycle pulse)
//   grant       one-hot registered grant, zero when idle
//   grant_id    binary index of the granted requester, zero when idle
//   grant_valid high while a grant is held
module axicb_rr_arbiter_lock #(
  parameter int REQ_NB = 4,
  parameter int PRIO_W = 2,
  localparam int ID_W = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     srst,
  input  logic                     en,
  input  logic [REQ_NB-1:0]        req,
  input  logic [REQ_NB*PRIO_W-1:0] prio,
  input  logic                     done,
  output logic [REQ_NB-1:0]        grant,
  output logic [ID_W-1:0]          grant_id,
  output logic                     grant_valid
);

  localparam int LVL_NB = 1 << PRIO_W;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [REQ_NB-1:0]   mask_q [LVL_NB];
  logic [REQ_NB-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic [PRIO_W-1:0]   top;
  logic [REQ_NB-1:0]   cand;
  logic [REQ_NB-1:0]   masked;
  logic [REQ_NB-1:0]   pick;
  logic [REQ_NB-1:0]   win_oh;
  logic [ID_W-1:0]     win_id;
  logic [REQ_NB-1:0]   next_mask;
  logic                found;
  logic                fire;

  // Winner selection: highest asserted priority level, then round-robin
  // within that level using the level's mask.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < REQ_NB; i++) begin
      if (req[i] && (prio[i*PRIO_W +: PRIO_W] > top)) begin
        top = prio[i*PRIO_W +: PRIO_W];
      end
    end

    cand = '0;
    for (int unsigned i = 0; i < REQ_NB; i++) begin
      cand[i] = req[i] && (prio[i*PRIO_W +: PRIO_W] == top);
    end

    masked = cand & mask_q[top];
    pick   = (|masked) ? masked : cand;

    found  = 1'b0;
    win_id = '0;
    win_oh = '0;
    for (int unsigned i = 0; i < REQ_NB; i++) begin
      if (pick[i] && !found) begin
        found     = 1'b1;
        win_id    = ID_W'(i);
        win_oh[i] = 1'b1;
      end
    end

    // Only requesters strictly above the winner stay eligible first; when the
    // winner is the last index the level starts over with everyone eligible.
    next_mask = '0;
    for (int unsigned i = 0; i < REQ_NB; i++) begin
      next_mask[i] = (ID_W'(i) > win_id);
    end
    if (next_mask == '0) begin
      next_mask = '1;
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    fire    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          fire    = 1'b1;
          state_d = LOCKED;
          grant_d = win_oh;
          id_d    = win_id;
        end
      end
      LOCKED: begin
        if (done) begin
          if (en && (|req)) begin
            fire    = 1'b1;
            grant_d = win_oh;
            id_d    = win_id;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      for (int unsigned l = 0; l < LVL_NB; l++) begin
        mask_q[l] <= '1;
      end
    end else if (srst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      for (int unsigned l = 0; l < LVL_NB; l++) begin
        mask_q[l] <= '1;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      if (fire) begin
        mask_q[top] <= next_mask;
      end
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = |grant_q;

endmodule

// File: tb/tb_axicb_rr_arbiter_lock.sv
module tb_axicb_rr_arbiter_lock;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic areset, srst, en, done;

  logic [3:0]  req0;  logic [7:0]  prio0; logic [3:0]  g0; logic [1:0] id0; logic gv0;
  logic [0:0]  req1;  logic [0:0]  prio1; logic [0:0]  g1; logic [0:0] id1; logic gv1;
  logic [6:0]  req2;  logic [6:0]  prio2; logic [6:0]  g2; logic [2:0] id2; logic gv2;
  logic [31:0] req3;  logic [31:0] prio3; logic [31:0] g3; logic [4:0] id3; logic gv3;

  axicb_rr_arbiter_lock #(.REQ_NB(4), .PRIO_W(2)) u0 (
    .aclk(aclk), .areset(areset), .srst(srst), .en(en), .req(req0), .prio(prio0),
    .done(done), .grant(g0), .grant_id(id0), .grant_valid(gv0));
  axicb_rr_arbiter_lock #(.REQ_NB(1), .PRIO_W(1)) u1 (
    .aclk(aclk), .areset(areset), .srst(srst), .en(en), .req(req1), .prio(prio1),
    .done(done), .grant(g1), .grant_id(id1), .grant_valid(gv1));
  axicb_rr_arbiter_lock #(.REQ_NB(7), .PRIO_W(1)) u2 (
    .aclk(aclk), .areset(areset), .srst(srst), .en(en), .req(req2), .prio(prio2),
    .done(done), .grant(g2), .grant_id(id2), .grant_valid(gv2));
  axicb_rr_arbiter_lock #(.REQ_NB(32), .PRIO_W(1)) u3 (
    .aclk(aclk), .areset(areset), .srst(srst), .en(en), .req(req3), .prio(prio3),
    .done(done), .grant(g3), .grant_id(id3), .grant_valid(gv3));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] act_g(input int k);
    case (k)
      0: return 32'(g0);
      1: return 32'(g1);
      2: return 32'(g2);
      default: return g3;
    endcase
  endfunction

  function automatic logic [31:0] act_id(input int k);
    case (k)
      0: return 32'(id0);
      1: return 32'(id1);
      2: return 32'(id2);
      default: return 32'(id3);
    endcase
  endfunction

  function automatic logic act_gv(input int k);
    case (k)
      0: return gv0;
      1: return gv1;
      2: return gv2;
      default: return gv3;
    endcase
  endfunction

  // ---------------- directed vector table (4-requester instance) ----------
  typedef struct {
    logic [3:0] req;
    logic [7:0] prio;
    logic       en;
    logic       done;
    logic       srst;
    logic [3:0] eg;
    logic [1:0] eid;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] r, input logic [7:0] p, input logic e,
                              input logic d, input logic s, input logic [3:0] g,
                              input logic [1:0] id);
    vec_t v;
    v.req = r; v.prio = p; v.en = e; v.done = d; v.srst = s; v.eg = g; v.eid = id;
    tbl.push_back(v);
  endfunction

  // ---------------- behavioural reference model ---------------------------
  // Each level remembers the index it granted last; the next winner at that
  // level is the lowest candidate above it, otherwise the lowest candidate.
  int          m_n  [4] = '{4, 1, 7, 32};
  int          m_lv [4] = '{4, 2, 2, 2};
  logic [31:0] m_req[4];
  int          m_prio[4][32];
  int          m_last[4][4];
  int          m_owner[4];

  task automatic mdl_reset();
    for (int k = 0; k < 4; k++) begin
      m_owner[k] = -1;
      for (int l = 0; l < 4; l++) m_last[k][l] = -1;
    end
  endtask

  task automatic mdl_step(input int k);
    int top, win;
    if (srst) begin
      m_owner[k] = -1;
      for (int l = 0; l < 4; l++) m_last[k][l] = -1;
    end else if (m_owner[k] < 0 || done) begin
      if (en && m_req[k] != 0) begin
        top = -1;
        for (int i = 0; i < m_n[k]; i++)
          if (m_req[k][i] && m_prio[k][i] > top) top = m_prio[k][i];
        win = -1;
        for (int i = 0; i < m_n[k]; i++)
          if (win < 0 && m_req[k][i] && m_prio[k][i] == top && i > m_last[k][top]) win = i;
        for (int i = 0; i < m_n[k]; i++)
          if (win < 0 && m_req[k][i] && m_prio[k][i] == top) win = i;
        m_owner[k] = win;
        m_last[k][top] = win;
      end else begin
        m_owner[k] = -1;
      end
    end
  endtask

  function automatic logic [31:0] exp_g(input int k);
    return (m_owner[k] < 0) ? 32'd0 : (32'd1 << m_owner[k]);
  endfunction

  function automatic logic [31:0] exp_id(input int k);
    return (m_owner[k] < 0) ? 32'd0 : 32'(m_owner[k]);
  endfunction

  task automatic drive_model();
    req0 = m_req[0][3:0];
    for (int i = 0; i < 4; i++) prio0[i*2 +: 2] = 2'(m_prio[0][i]);
    req1 = m_req[1][0:0];
    prio1[0] = m_prio[1][0][0];
    req2 = m_req[2][6:0];
    for (int i = 0; i < 7; i++) prio2[i] = m_prio[2][i][0];
    req3 = m_req[3];
    for (int i = 0; i < 32; i++) prio3[i] = m_prio[3][i][0];
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_grant_k%0d", tag, k), act_g(k), exp_g(k));
      chk($sformatf("%s_id_k%0d", tag, k), act_id(k), exp_id(k));
      chk($sformatf("%s_valid_k%0d", tag, k), 32'(act_gv(k)), 32'(m_owner[k] >= 0));
      chk($sformatf("%s_onehot_k%0d", tag, k), 32'($onehot0(act_g(k))), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] prev_exp[4];
    logic        prev_done, prev_srst;
    logic [31:0] r;
    int          cnt[4];
    int          hits[4][32];
    logic        ok;

    areset = 1'b1; srst = 1'b0; en = 1'b0; done = 1'b0;
    req0 = '0; prio0 = '0; req1 = '0; prio1 = '0;
    req2 = '0; prio2 = '0; req3 = '0; prio3 = '0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_grant_k%0d", k), act_g(k), 32'd0);
      chk($sformatf("reset_id_k%0d", k), act_id(k), 32'd0);
      chk($sformatf("reset_valid_k%0d", k), 32'(act_gv(k)), 32'd0);
    end
    @(negedge aclk);
    areset = 1'b0;

    // rotation
    add(4'b1111, 8'h00, 1, 0, 0, 4'b0001, 0);
    add(4'b1111, 8'h00, 1, 1, 0, 4'b0010, 1);
    add(4'b1111, 8'h00, 1, 1, 0, 4'b0100, 2);
    add(4'b1111, 8'h00, 1, 1, 0, 4'b1000, 3);
    add(4'b1111, 8'h00, 1, 1, 0, 4'b0001, 0);
    add(4'b0000, 8'h00, 1, 1, 0, 4'b0000, 0);
    add(4'b0000, 8'h00, 1, 0, 1, 4'b0000, 0);
    // skip and wrap, then narrowed request set
    add(4'b1101, 8'h00, 1, 0, 0, 4'b0001, 0);
    add(4'b1101, 8'h00, 1, 1, 0, 4'b0100, 2);
    add(4'b1101, 8'h00, 1, 1, 0, 4'b1000, 3);
    add(4'b1101, 8'h00, 1, 1, 0, 4'b0001, 0);
    add(4'b0011, 8'h00, 1, 1, 0, 4'b0010, 1);
    add(4'b0011, 8'h00, 1, 1, 0, 4'b0001, 0);
    add(4'b0011, 8'h00, 1, 1, 0, 4'b0010, 1);
    add(4'b0000, 8'h00, 1, 1, 0, 4'b0000, 0);
    add(4'b0000, 8'h00, 1, 0, 1, 4'b0000, 0);
    // priority layering; last entry shows mask[2] held at 1000
    add(4'b1111, 8'h20, 1, 0, 0, 4'b0100, 2);
    add(4'b1011, 8'h20, 1, 1, 0, 4'b0001, 0);
    add(4'b1011, 8'h20, 1, 1, 0, 4'b0010, 1);
    add(4'b1100, 8'hA0, 1, 1, 0, 4'b1000, 3);
    // lock hold on requester 1
    add(4'b0010, 8'h00, 1, 1, 0, 4'b0010, 1);
    for (int i = 0; i < 10; i++) add(4'b1000, 8'hC0, 1, 0, 0, 4'b0010, 1);
    add(4'b1000, 8'hC0, 1, 1, 0, 4'b1000, 3);
    // enable and idle
    add(4'b0000, 8'h00, 1, 1, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) add(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 0);
    add(4'b1111, 8'h00, 0, 1, 0, 4'b0000, 0);
    add(4'b0000, 8'h00, 1, 1, 0, 4'b0000, 0);
    add(4'b1111, 8'h00, 1, 0, 0, 4'b0100, 2);
    add(4'b0000, 8'h00, 1, 1, 0, 4'b0000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      req0 = tbl[i].req; prio0 = tbl[i].prio; en = tbl[i].en;
      done = tbl[i].done; srst = tbl[i].srst;
      tick();
      chk($sformatf("vec%0d_grant", i), 32'(g0), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_id", i), 32'(id0), 32'(tbl[i].eid));
      chk($sformatf("vec%0d_valid", i), 32'(gv0), 32'(|tbl[i].eg));
    end
    done = 1'b0; srst = 1'b0;

    // asynchronous reset mid-grant
    req0 = 4'b0100; prio0 = '0; en = 1'b1;
    tick();
    chk("areset_pre_grant", 32'(g0), 32'h4);
    #2 areset = 1'b1;
    #1;
    chk("areset_grant", 32'(g0), 32'h0);
    chk("areset_id", 32'(id0), 32'h0);
    chk("areset_valid", 32'(gv0), 32'h0);
    @(negedge aclk);
    areset = 1'b0; req0 = 4'b1111;
    tick();
    chk("areset_after_grant", 32'(g0), 32'h1);
    req0 = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    chk("areset_release", 32'(g0), 32'h0);

    // synchronous reset mid-grant
    req0 = 4'b0100;
    tick();
    chk("srst_pre_grant", 32'(g0), 32'h4);
    srst = 1'b1;
    #2;
    chk("srst_not_async", 32'(g0), 32'h4);
    tick();
    chk("srst_grant", 32'(g0), 32'h0);
    chk("srst_valid", 32'(gv0), 32'h0);
    srst = 1'b0; req0 = 4'b1111;
    tick();
    chk("srst_after_grant", 32'(g0), 32'h1);
    chk("srst_after_id", 32'(id0), 32'h0);

    // randomized run of all instances against the reference model
    for (int k = 0; k < 4; k++) begin
      m_req[k] = '0;
      for (int i = 0; i < 32; i++) m_prio[k][i] = 0;
    end
    drive_model();
    srst = 1'b1; done = 1'b0;
    tick();
    srst = 1'b0;
    mdl_reset();
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom_range(0, 9) < 8);
      done = ($urandom_range(0, 9) < 3);
      srst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 4; k++) begin
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r = r & $urandom;
        if ($urandom_range(0, 7) == 0) r = '0;
        if (m_n[k] < 32) r = r & ((32'd1 << m_n[k]) - 32'd1);
        m_req[k] = r;
        for (int i = 0; i < 32; i++) m_prio[k][i] = $urandom_range(0, m_lv[k] - 1);
      end
      drive_model();
      for (int k = 0; k < 4; k++) prev_exp[k] = exp_g(k);
      prev_done = done; prev_srst = srst;
      for (int k = 0; k < 4; k++) mdl_step(k);
      tick();
      compare_all("rand");
      for (int k = 0; k < 4; k++)
        if (prev_exp[k] != 0 && !prev_done && !prev_srst)
          chk($sformatf("lock_hold_k%0d", k), act_g(k), prev_exp[k]);
    end

    // fairness: fixed request subsets, equal priority, done every cycle
    srst = 1'b0; en = 1'b1; done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r = $urandom;
      if (m_n[k] < 32) r = r & ((32'd1 << m_n[k]) - 32'd1);
      if (r == 0) r = 32'd1;
      m_req[k] = r;
      cnt[k] = $countones(r);
      for (int i = 0; i < 32; i++) begin
        m_prio[k][i] = 0;
        hits[k][i] = 0;
      end
    end
    drive_model();
    for (int c = 0; c < 64; c++) begin
      for (int k = 0; k < 4; k++) mdl_step(k);
      tick();
      compare_all("fair");
      for (int k = 0; k < 4; k++)
        if (c < 2 * cnt[k] && act_gv(k)) hits[k][act_id(k)]++;
    end
    for (int k = 0; k < 4; k++) begin
      ok = 1'b1;
      for (int i = 0; i < m_n[k]; i++)
        if (hits[k][i] != (m_req[k][i] ? 2 : 0)) ok = 1'b0;
      chk($sformatf("fairness_k%0d", k), 32'(ok), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axicb_rr_arbiter_lock.md
Name: axicb_rr_arbiter_lock

Overview:
- Parametrised round-robin arbiter for the AXI crossbar.
- Supports any requester count and multi-level priority, with one round-robin mask per priority level.
- Registers the grant and holds it locked until the owner signals completion.
- Replaces the fixed 4/8-requester combinational arbiter in switch slave/master channel arbitration, so a granted burst cannot be pre-empted mid-transfer.

Parameters:
- REQ_NB, 4, number of requesters; legal range 1..32.
- PRIO_W, 2, width of each requester's priority field; 2**PRIO_W levels; higher value wins.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous reset, active-high.
- srst  in  1  synchronous reset, active-high; same effect as areset on the next edge.
- en  in  1  arbitration enable; no new grant is issued while low.
- req  in  REQ_NB  request vector, one bit per requester.
- prio  in  REQ_NB*PRIO_W  priority of requester i in bits [i*PRIO_W +: PRIO_W].
- done  in  1  current owner releases its grant; single-cycle pulse.
- grant  out  REQ_NB  one-hot registered grant; all zeros when idle.
- grant_id  out  max(1,$clog2(REQ_NB))  binary index of the granted requester; 0 when idle.
- grant_valid  out  1  high while a grant is held; equals |grant.

Behaviour:
- Reset values (areset or srst):
  - grant=0, grant_id=0, grant_valid=0.
  - State IDLE.
  - All 2**PRIO_W masks all-ones.
- State IDLE (no grant held):
  - top = highest prio value among asserted req bits.
  - cand = req bits whose prio == top.
  - masked = cand & mask[top].
  - Winner = lowest set index of masked if masked != 0, else lowest set index of cand.
- Issuing a grant:
  - Condition: en=1 and |req in IDLE.
  - On the next edge: grant=onehot(winner), grant_id=winner, grant_valid=1, state goes to LOCKED.
  - Latency is one cycle from req to grant.
- Mask update on a grant:
  - mask[top] <= bits strictly above winner set, all others clear.
  - If that result is zero (winner is index REQ_NB-1), mask[top] <= all-ones.
  - Masks of other priority levels are unchanged.
- State LOCKED:
  - grant, grant_id and prio bookkeeping are held stable, irrespective of req, prio or en changes.
  - Deassertion of the owner's req does not release the grant; only done does.
- done in LOCKED:
  - If en=1 and |req in the same cycle, re-arbitrate combinationally exactly as in IDLE, using the current masks and current req/prio.
  - The new grant is loaded on that edge, giving back-to-back grants with no bubble; the releasing owner may win again only per mask rules.
  - Otherwise grant clears on that edge and state goes to IDLE.
- done in IDLE is ignored.
- en low in IDLE: no grant is issued and masks are frozen.
- REQ_NB=1: the mask is always all-ones; the single requester is granted whenever it requests and en=1.
- areset or srst mid-grant: the grant drops immediately (async) or on the next edge (sync); masks return to all-ones.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_id matches grant.
- Fairness: among continuously requesting equal-top-priority requesters, each is granted once every N grants, N = their count.

Test Plan:
- Rotation (REQ_NB=4, all prio=0, req=1111, done pulsed one cycle after each grant, en=1): grant sequence 0001,0010,0100,1000,0001; grant_id 0,1,2,3,0.
- Skip and wrap (req=1101, prio=0): grants 0001,0100,1000,0001. Then change req to 0011 after grant 0010: next grant is 0001 and mask[0] becomes 1110.
- Priority layering (REQ_NB=4, prio[2]=2, others 0, req=1111):
  - First grant 0100.
  - Then drop req[2], giving req=1011: grants 0001, then 0010.
  - mask[2] stays 1000 while the level-0 grants rotate.
- Lock hold (grant on req 1):
  - Drop req[1] and raise req[3] with prio 3, done held low for 10 cycles: grant stays 0010 throughout.
  - Then pulse done: next edge grant=1000 with no idle cycle.
- Enable and idle:
  - en=0, req=1111 for 5 cycles: grant stays 0000 and masks are unchanged.
  - done pulsed in IDLE: no state change.
  - done with req=0000 in LOCKED: grant goes to 0000 on the next edge.
- Reset mid-grant (grant=0100):
  - Assert areset between edges: grant, grant_id and grant_valid clear immediately.
  - After release with req=1111: grant is 0001.
  - Repeat the same sequence with srst: clear occurs at the next edge.
- Parameter sweep: REQ_NB=1, 7 and 32 with PRIO_W=1 and random req/prio/done. Assertions checked:
  - one-hot grant;
  - no grant change while LOCKED without done;
  - fairness bound of N grants.
